// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Byte-addressed load/store front end for a word-wide synchronous
//            data memory; sub-word stores use read-modify-write.
// Revision : 1.0  initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_data_in,
    output logic                  mem_we,
    input  logic [31:0]           mem_data_out
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    logic [2:0]            state_q, state_d;
    logic [2:0]            f3_q;
    logic                  we_q;
    logic [1:0]            lane_q;
    logic [15:0]           wdata_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_data_in_q;
    logic [31:0]           rsp_rdata_q;
    logic                  rsp_err_q;

    logic                  w_err;
    logic                  w_is_sw;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load;
    logic [31:0]           w_merged;
    logic                  w_unused_addr;

    // Upper address bits are deliberately dropped so accesses wrap.
    assign w_unused_addr = ^{req_addr[31:ADDR_WIDTH+2]};

    always_comb begin
        w_err = 1'b1;
        case (req_funct3)
            c_F3_B:  w_err = 1'b0;
            c_F3_H:  w_err = req_addr[0];
            c_F3_W:  w_err = (req_addr[1:0] != 2'b00);
            c_F3_BU: w_err = req_we;
            c_F3_HU: w_err = req_we | req_addr[0];
            default: w_err = 1'b1;
        endcase
    end

    assign w_is_sw = req_we && (req_funct3 == c_F3_W);

    // Lane selection from the word returned for the address registered in RD.
    always_comb begin
        w_byte = mem_data_out[7:0];
        case (lane_q)
            2'd0:    w_byte = mem_data_out[7:0];
            2'd1:    w_byte = mem_data_out[15:8];
            2'd2:    w_byte = mem_data_out[23:16];
            default: w_byte = mem_data_out[31:24];
        endcase
        w_half = lane_q[1] ? mem_data_out[31:16] : mem_data_out[15:0];
        case (f3_q)
            c_F3_B:  w_load = {{24{w_byte[7]}}, w_byte};
            c_F3_BU: w_load = {24'h0, w_byte};
            c_F3_H:  w_load = {{16{w_half[15]}}, w_half};
            c_F3_HU: w_load = {16'h0, w_half};
            default: w_load = mem_data_out;
        endcase
    end

    always_comb begin
        w_merged = mem_data_out;
        if (f3_q[0]) begin
            if (lane_q[1]) w_merged[31:16] = wdata_q;
            else           w_merged[15:0]  = wdata_q;
        end else begin
            case (lane_q)
                2'd0:    w_merged[7:0]   = wdata_q[7:0];
                2'd1:    w_merged[15:8]  = wdata_q[7:0];
                2'd2:    w_merged[23:16] = wdata_q[7:0];
                default: w_merged[31:24] = wdata_q[7:0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (w_err)        state_d = S_RESP;
                    else if (w_is_sw) state_d = S_WR;
                    else              state_d = S_RD;
                end
            end
            S_RD:    state_d = S_DATA;
            S_DATA:  state_d = we_q ? S_WR : S_RESP;
            S_WR:    state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        mem_we    = (state_q == S_WR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q          <= 3'd0;
            we_q          <= 1'b0;
            lane_q        <= 2'd0;
            wdata_q       <= 16'h0;
            mem_addr_q    <= '0;
            mem_data_in_q <= 32'h0;
            rsp_rdata_q   <= 32'h0;
            rsp_err_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        f3_q       <= req_funct3;
                        we_q       <= req_we;
                        lane_q     <= req_addr[1:0];
                        wdata_q    <= req_wdata[15:0];
                        mem_addr_q <= req_addr[ADDR_WIDTH+1:2];
                        if (w_err) begin
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                        end else if (w_is_sw) begin
                            mem_data_in_q <= req_wdata;
                        end
                    end
                end
                S_DATA: begin
                    if (we_q) begin
                        mem_data_in_q <= w_merged;
                    end else begin
                        rsp_rdata_q <= w_load;
                        rsp_err_q   <= 1'b0;
                    end
                end
                S_WR: begin
                    rsp_rdata_q <= 32'h0;
                    rsp_err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_data_in = mem_data_in_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed self-checking bench for load_store_unit with a
//            synchronous-read word memory model.
// Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    localparam int ADDR_WIDTH = 8;

    logic                  clk;
    logic                  rst_n;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_data_in;
    logic                  mem_we;
    logic [31:0]           mem_data_out;

    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];

    int n_checks = 0;
    int n_errors = 0;

    load_store_unit #(.ADDR_WIDTH(ADDR_WIDTH)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_we       (mem_we),
        .mem_data_out (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_data_in;
        mem_data_out <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // One full transaction: returns response data, error flag, latency and
    // the number of sampled cycles with mem_we high.
    task automatic xfer(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err,
                        output int lat, output int wecnt);
        @(negedge clk);
        chk("ready_before_req", {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat   = 1;
        wecnt = 0;
        while (!rsp_valid && lat < 20) begin
            if (mem_we) wecnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!rsp_valid) chk("rsp_timeout", 32'h0, 32'h1);
        rd  = rsp_rdata;
        err = rsp_err;
        @(posedge clk);
        #1;
        chk("rsp_pulse_one_cycle", {31'h0, rsp_valid}, 32'h0);
        chk("rsp_rdata_holds", rsp_rdata, rd);
    endtask

    logic [31:0] rd;
    logic        err;
    int          lat;
    int          wecnt;

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        chk("rst_mem_addr", {24'h0, mem_addr}, 32'h0);
        chk("rst_mem_data_in", mem_data_in, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // SW then LW
        xfer(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, err, lat, wecnt);
        chk("sw_lat", lat, 2);
        chk("sw_we_cycles", wecnt, 1);
        chk("sw_err", {31'h0, err}, 32'h0);
        chk("sw_rdata", rd, 32'h0);
        xfer(1'b0, 3'b010, 32'h10, 32'h0, rd, err, lat, wecnt);
        chk("lw_lat", lat, 3);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_err", {31'h0, err}, 32'h0);
        chk("lw_we_cycles", wecnt, 0);

        // SB read-modify-write
        xfer(1'b1, 3'b010, 32'h10, 32'h11223344, rd, err, lat, wecnt);
        xfer(1'b1, 3'b000, 32'h11, 32'hFFFFFFA5, rd, err, lat, wecnt);
        chk("sb_lat", lat, 4);
        chk("sb_we_cycles", wecnt, 1);
        chk("sb_err", {31'h0, err}, 32'h0);
        xfer(1'b0, 3'b010, 32'h10, 32'h0, rd, err, lat, wecnt);
        chk("sb_merge", rd, 32'h1122A544);

        // SH upper half
        xfer(1'b1, 3'b001, 32'h12, 32'h0000BEEF, rd, err, lat, wecnt);
        chk("sh_lat", lat, 4);
        xfer(1'b0, 3'b010, 32'h10, 32'h0, rd, err, lat, wecnt);
        chk("sh_merge", rd, 32'hBEEFA544);

        // Sign / zero extension
        xfer(1'b1, 3'b010, 32'h10, 32'h80FF0000, rd, err, lat, wecnt);
        xfer(1'b0, 3'b000, 32'h13, 32'h0, rd, err, lat, wecnt);
        chk("lb_sext", rd, 32'hFFFFFF80);
        xfer(1'b0, 3'b100, 32'h13, 32'h0, rd, err, lat, wecnt);
        chk("lbu_zext", rd, 32'h00000080);
        xfer(1'b0, 3'b001, 32'h12, 32'h0, rd, err, lat, wecnt);
        chk("lh_sext", rd, 32'hFFFF80FF);
        xfer(1'b0, 3'b101, 32'h12, 32'h0, rd, err, lat, wecnt);
        chk("lhu_zext", rd, 32'h000080FF);
        xfer(1'b0, 3'b000, 32'h11, 32'h0, rd, err, lat, wecnt);
        chk("lb_lane1", rd, 32'h00000000);

        // Errors: misaligned LW, misaligned SH, illegal load, illegal store
        xfer(1'b0, 3'b010, 32'h06, 32'h0, rd, err, lat, wecnt);
        chk("err_lw_lat", lat, 1);
        chk("err_lw_flag", {31'h0, err}, 32'h1);
        chk("err_lw_rdata", rd, 32'h0);
        chk("err_lw_we", wecnt, 0);
        xfer(1'b1, 3'b001, 32'h01, 32'h1234, rd, err, lat, wecnt);
        chk("err_sh_lat", lat, 1);
        chk("err_sh_flag", {31'h0, err}, 32'h1);
        chk("err_sh_we", wecnt, 0);
        xfer(1'b0, 3'b011, 32'h10, 32'h0, rd, err, lat, wecnt);
        chk("err_f3_lat", lat, 1);
        chk("err_f3_flag", {31'h0, err}, 32'h1);
        chk("err_f3_rdata", rd, 32'h0);
        xfer(1'b1, 3'b100, 32'h10, 32'h0, rd, err, lat, wecnt);
        chk("err_sbu_flag", {31'h0, err}, 32'h1);
        chk("err_sbu_we", wecnt, 0);
        xfer(1'b0, 3'b010, 32'h10, 32'h0, rd, err, lat, wecnt);
        chk("err_mem_untouched", rd, 32'h80FF0000);
        chk("err_clears_on_load", {31'h0, err}, 32'h0);

        // Reset asserted while the SB write cycle is pending
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h10;
        req_wdata  = 32'h77;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("abort_in_wr", {31'h0, mem_we}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_we_drop", {31'h0, mem_we}, 32'h0);
        chk("abort_no_rsp", {31'h0, rsp_valid}, 32'h0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("abort_rsp_in_rst", {31'h0, rsp_valid}, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort_rsp_after", {31'h0, rsp_valid}, 32'h0);
        end
        chk("abort_ready", {31'h0, req_ready}, 32'h1);
        xfer(1'b0, 3'b010, 32'h10, 32'h0, rd, err, lat, wecnt);
        chk("abort_mem_unchanged", rd, 32'h80FF0000);

        // Address wrap-around
        xfer(1'b1, 3'b010, (32'd4 << ADDR_WIDTH) + 32'd4, 32'hCAFEF00D, rd, err, lat, wecnt);
        xfer(1'b0, 3'b010, 32'h4, 32'h0, rd, err, lat, wecnt);
        chk("wrap_rdata", rd, 32'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
